// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the 5-stage MIPS pipeline.
//
// Sits between the ID/EX and EX/MEM latches. Forwards rs/rt from EX/MEM and
// MEM/WB, selects ALU sources, computes the ALU result and destination
// register, and passes memory/writeback controls through. An optional
// iterative shift-add multiplier (alu_control = 4'b1111) runs for 32 steps
// and holds the upstream pipeline via `stall` while it works.
//
// Build option:
//   EX_MUL_EN  defined   -> multiplier FSM present, op 1111 = low 32 bits of A*B
//              undefined -> op 1111 yields 0, stall tied low, no FSM registers
//
// Ports:
//   clk, reset        clock (state updates on negedge), sync active-high reset
//   step_en           debug step enable; 0 freezes the multiplier FSM
//   alu_control.. load_imm           decoded fields from ID/EX
//   *_in              memory/writeback controls from ID/EX
//   exmem_*, memwb_*  forwarding sources
//   alu_result        ALU / LUI / multiplier result
//   store_data        forwarded rt value
//   write_reg         rd when reg_dst, else rt
//   *_out             controls to EX/MEM (write-type controls bubbled on stall)
//   stall             freeze ID/EX and upstream stages
module ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step_en,
    input  logic [3:0]   alu_control,
    input  logic         alu_src,
    input  logic         alu_shift_imm,
    input  logic [4:0]   sa,
    input  logic [W-1:0] sign_imm,
    input  logic [W-1:0] read_data1,
    input  logic [W-1:0] read_data2,
    input  logic [4:0]   rs,
    input  logic [4:0]   rt,
    input  logic [4:0]   rd,
    input  logic         reg_dst,
    input  logic         load_imm,
    input  logic         reg_write_in,
    input  logic         mem_to_reg_in,
    input  logic [1:0]   mem_read_width_in,
    input  logic [3:0]   mem_write_in,
    input  logic         eop_in,
    input  logic         exmem_reg_write,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_result,
    output logic [W-1:0] alu_result,
    output logic [W-1:0] store_data,
    output logic [4:0]   write_reg,
    output logic         reg_write_out,
    output logic         mem_to_reg_out,
    output logic [1:0]   mem_read_width_out,
    output logic [3:0]   mem_write_out,
    output logic         eop_out,
    output logic         stall
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADDU = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SUBU = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    logic [W-1:0] opA, opB, srcB, aluOut, mulResult;
    logic [4:0]   shamt;
    logic         exHitA, exHitB, wbHitA, wbHitB;

    // ---- forwarding: EX/MEM beats MEM/WB, $0 never forwarded ----
    assign exHitA = exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs);
    assign exHitB = exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt);
    assign wbHitA = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs);
    assign wbHitB = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt);

    assign opA = exHitA ? exmem_result : (wbHitA ? memwb_result : read_data1);
    assign opB = exHitB ? exmem_result : (wbHitB ? memwb_result : read_data2);

    assign srcB  = alu_src ? sign_imm : opB;
    // shifts always act on rt; variable shifts take the amount from rs
    assign shamt = alu_shift_imm ? sa : opA[4:0];

    always_comb begin
        aluOut = '0;
        unique case (alu_control)
            OP_AND:  aluOut = opA & srcB;
            OP_OR:   aluOut = opA | srcB;
            OP_ADDU: aluOut = opA + srcB;
            OP_XOR:  aluOut = opA ^ srcB;
            OP_NOR:  aluOut = ~(opA | srcB);
            OP_SUBU: aluOut = opA - srcB;
            OP_SLT:  aluOut = {{(W-1){1'b0}}, ($signed(opA) < $signed(srcB))};
            OP_SLTU: aluOut = {{(W-1){1'b0}}, (opA < srcB)};
            OP_SLL:  aluOut = opB << shamt;
            OP_SRL:  aluOut = opB >> shamt;
            OP_SRA:  aluOut = W'($signed(opB) >>> shamt);
            OP_MUL:  aluOut = mulResult;
            default: aluOut = '0;
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

    mulState_t    state, stateNext;
    logic [W-1:0] mcand, mplier, acc;
    logic [4:0]   cnt;
    logic         isMul, mulStall;

    assign isMul = (alu_control == OP_MUL);

    always_ff @(negedge clk) begin
        if (reset)
            state <= IDLE;
        else if (step_en)
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        mulStall  = 1'b0;
        case (state)
            IDLE: begin
                mulStall = isMul;
                if (isMul) stateNext = BUSY;
            end
            BUSY: begin
                mulStall = 1'b1;
                if (cnt == 5'd31) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // shift-add datapath: examine multiplier LSB, shift both operands
    always_ff @(negedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (step_en) begin
            case (state)
                IDLE: if (isMul) begin
                    mcand  <= opA;
                    mplier <= srcB;
                    acc    <= '0;
                    cnt    <= '0;
                end
                BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign mulResult = acc;
    assign stall     = mulStall;
`else
    logic unusedSig;
    assign unusedSig = ^{clk, reset, step_en};
    assign mulResult = '0;
    assign stall     = 1'b0;
`endif

    // LUI bypasses the ALU entirely
    assign alu_result = load_imm ? {sign_imm[15:0], {(W-16){1'b0}}} : aluOut;
    assign store_data = opB;
    assign write_reg  = reg_dst ? rd : rt;

    // bubble the state-changing controls while the pipe is frozen
    assign reg_write_out      = reg_write_in & ~stall;
    assign mem_write_out      = stall ? 4'b0000 : mem_write_in;
    assign eop_out            = eop_in & ~stall;
    assign mem_to_reg_out     = mem_to_reg_in;
    assign mem_read_width_out = mem_read_width_in;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected results, a monitor
// pops and compares whenever the stage presents a non-stalled output.
module tb_ex_stage;

    logic        clk, reset, step_en;
    logic [3:0]  alu_control;
    logic        alu_src, alu_shift_imm, reg_dst, load_imm;
    logic [4:0]  sa, rs, rt, rd;
    logic [31:0] sign_imm, read_data1, read_data2;
    logic        reg_write_in, mem_to_reg_in, eop_in;
    logic [1:0]  mem_read_width_in;
    logic [3:0]  mem_write_in;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_result, store_data;
    logic [4:0]  write_reg;
    logic        reg_write_out, mem_to_reg_out, eop_out, stall;
    logic [1:0]  mem_read_width_out;
    logic [3:0]  mem_write_out;

    ex_stage #(.W(32)) dut (
        .clk(clk), .reset(reset), .step_en(step_en),
        .alu_control(alu_control), .alu_src(alu_src), .alu_shift_imm(alu_shift_imm),
        .sa(sa), .sign_imm(sign_imm), .read_data1(read_data1), .read_data2(read_data2),
        .rs(rs), .rt(rt), .rd(rd), .reg_dst(reg_dst), .load_imm(load_imm),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_read_width_in(mem_read_width_in), .mem_write_in(mem_write_in), .eop_in(eop_in),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_result(alu_result), .store_data(store_data), .write_reg(write_reg),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
        .mem_read_width_out(mem_read_width_out), .mem_write_out(mem_write_out),
        .eop_out(eop_out), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  wreg;
        logic [31:0] sdata;
        logic        rw;
        logic [3:0]  mw;
        logic        eop;
        logic        mtr;
        logic [1:0]  mrw;
        int          stalls;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stallCnt = 0;
    bit   rstSeen = 0;
    exp_t e;

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
        end
    endtask

    // monitor: samples on posedge, away from the negedge the stage updates on
    always @(posedge clk) begin
        if (reset) begin
            stallCnt = 0;
            rstSeen  = 1;
        end else begin
            if (rstSeen && alu_control == 4'hF)
                cmp("post_reset", "acc", alu_result, 32'h0);
            rstSeen = 0;
            if (stall === 1'b1) begin
                stallCnt++;
                cmp("stall", "bubble", 32'({reg_write_out, mem_write_out, eop_out}), 32'h0);
                if (stallCnt > 100) begin
                    cmp("stall", "timeout", 32'(stallCnt), 32'd100);
                    if (q.size() > 0) void'(q.pop_front());
                    stallCnt = 0;
                end
            end else if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "result", alu_result, e.res);
                cmp(e.name, "write_reg", 32'(write_reg), 32'(e.wreg));
                cmp(e.name, "store_data", store_data, e.sdata);
                cmp(e.name, "reg_write", 32'(reg_write_out), 32'(e.rw));
                cmp(e.name, "mem_write", 32'(mem_write_out), 32'(e.mw));
                cmp(e.name, "eop", 32'(eop_out), 32'(e.eop));
                cmp(e.name, "mem_to_reg", 32'(mem_to_reg_out), 32'(e.mtr));
                cmp(e.name, "rd_width", 32'(mem_read_width_out), 32'(e.mrw));
                cmp(e.name, "stalls", 32'(stallCnt), 32'(e.stalls));
                stallCnt = 0;
            end else begin
                stallCnt = 0;
            end
        end
    end

    task automatic nop();
        alu_control = 4'h0; alu_src = 0; alu_shift_imm = 0; sa = 0; sign_imm = 0;
        read_data1 = 0; read_data2 = 0; rs = 0; rt = 0; rd = 0; reg_dst = 0; load_imm = 0;
        reg_write_in = 0; mem_to_reg_in = 0; mem_read_width_in = 0; mem_write_in = 0; eop_in = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    // pass-through controls are expected to equal the driven inputs once unstalled
    task automatic push(input string nm, input logic [31:0] res, input logic [4:0] wr,
                        input logic [31:0] sd, input int st);
        exp_t x;
        x.name = nm; x.res = res; x.wreg = wr; x.sdata = sd; x.stalls = st;
        x.rw = reg_write_in; x.mw = mem_write_in; x.eop = eop_in;
        x.mtr = mem_to_reg_in; x.mrw = mem_read_width_in;
        q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0) return;
        end
        $display("FAIL drain timeout got %0d pending want 0", q.size());
        $fatal(1, "scoreboard did not drain");
    endtask

    logic [3:0]  logOp  [6] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'hC};
    logic [31:0] logExp [6] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h000F000F, 32'h0, 32'h0};

    initial begin
        reset = 1; step_en = 1; nop();
        repeat (3) @(negedge clk);
        #1 reset = 0;
        push("reset", 32'h0, 5'd0, 32'h0, 0);
        drain();

        #1 nop(); alu_control = 4'h2; rs = 1; read_data1 = 5; rt = 2; read_data2 = 7;
        rd = 9; reg_dst = 1; reg_write_in = 1; mem_to_reg_in = 1; mem_read_width_in = 2'd2;
        push("addu", 32'd12, 5'd9, 32'd7, 0);
        drain();

        #1 nop(); alu_control = 4'h2; rs = 3; read_data1 = 32'h11; rt = 0; read_data2 = 32'h22;
        reg_write_in = 1;
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAAAA;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h5555;
        push("fwd_exmem", 32'hAACC, 5'd0, 32'h22, 0);
        drain();

        #1 exmem_reg_write = 0;
        push("fwd_memwb", 32'h5577, 5'd0, 32'h22, 0);
        drain();

        #1 exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0; rs = 0;
        push("fwd_r0", 32'h33, 5'd0, 32'h22, 0);
        drain();

        #1 nop(); alu_control = 4'h6; rs = 1; read_data1 = 1; rt = 4; read_data2 = 32'h999;
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h100;
        memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h200;
        push("fwd_b_subu", 32'hFFFFFF01, 5'd4, 32'h100, 0);
        drain();

        #1 nop(); alu_control = 4'hB; alu_shift_imm = 1; sa = 4; rs = 1; read_data1 = 32'h1F;
        rt = 5; read_data2 = 32'h80000000;
        push("sra", 32'hF8000000, 5'd5, 32'h80000000, 0);
        drain();

        #1 alu_control = 4'hA; alu_shift_imm = 0; read_data1 = 32'h8;
        push("srlv", 32'h00800000, 5'd5, 32'h80000000, 0);
        drain();

        #1 alu_control = 4'h9; read_data1 = 32'h28; read_data2 = 32'hF1;
        push("sllv", 32'h0000F100, 5'd5, 32'hF1, 0);
        drain();

        #1 nop(); alu_control = 4'h7; rs = 1; read_data1 = 32'hFFFFFFFF; rt = 2; read_data2 = 1;
        push("slt", 32'h1, 5'd2, 32'h1, 0);
        drain();

        #1 alu_control = 4'h8;
        push("sltu", 32'h0, 5'd2, 32'h1, 0);
        drain();

        #1 nop(); alu_control = 4'h2; load_imm = 1; alu_src = 1; sign_imm = 32'h1234; rt = 8;
        reg_write_in = 1;
        push("lui", 32'h12340000, 5'd8, 32'h0, 0);
        drain();

        #1 nop(); alu_control = 4'h2; alu_src = 1; sign_imm = 32'hFFFFFFFF; rs = 1; read_data1 = 10;
        rt = 2; read_data2 = 32'h77;
        push("addiu", 32'd9, 5'd2, 32'h77, 0);
        drain();

        for (int i = 0; i < 6; i++) begin
            #1 nop(); alu_control = logOp[i]; rs = 1; read_data1 = 32'hF0F0F0F0;
            rt = 2; read_data2 = 32'h0FF00FF0; mem_write_in = 4'h3;
            push($sformatf("logic_op%0d", i), logExp[i], 5'd2, 32'h0FF00FF0, 0);
            drain();
        end

`ifdef EX_MUL_EN
        #1 nop(); alu_control = 4'hF; rs = 1; read_data1 = 32'hFFFF; rt = 2; read_data2 = 32'h10001;
        rd = 7; reg_dst = 1; reg_write_in = 1; mem_write_in = 4'hF; eop_in = 1;
        push("mul", 32'hFFFFFFFF, 5'd7, 32'h10001, 33);
        drain();

        #1 read_data1 = 3; read_data2 = 5;
        push("mul_b2b", 32'd15, 5'd7, 32'd5, 33);
        drain();

        #1 read_data1 = 32'h12345678; read_data2 = 32'h10;
        push("mul_step", 32'h23456780, 5'd7, 32'h10, 38);
        repeat (10) @(negedge clk);
        #1 step_en = 0;
        repeat (5) @(negedge clk);
        #1 step_en = 1;
        drain();

        #1 read_data1 = 32'hFFFF; read_data2 = 32'h10001;
        push("mul_reset", 32'hFFFFFFFF, 5'd7, 32'h10001, 33);
        repeat (11) @(negedge clk);
        #1 reset = 1;
        @(negedge clk);
        #1 reset = 0;
        drain();
`else
        #1 nop(); alu_control = 4'hF; rs = 1; read_data1 = 3; rt = 2; read_data2 = 5;
        reg_write_in = 1; eop_in = 1;
        push("mul_off", 32'h0, 5'd2, 32'h5, 0);
        drain();
`endif

        #1 nop();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline. It sits between the ID/EX latch, which feeds it, and the EX/MEM latch, which consumes its results. It forwards operands from EX/MEM and MEM/WB, selects ALU sources, computes the ALU result and the destination register, and passes the memory and writeback controls through. It also contains an iterative 32-cycle multiplier that stalls the pipeline while it runs.

## Interface
Parameters:
- `W`, default 32: datapath width. Only 32 is supported.

Ports (name, direction, width, meaning):
- `clk` in 1: clock. All state updates on the negedge, the same edge as the pipeline latches.
- `reset` in 1: reset, synchronous, active-high.
- `step_en` in 1: debug step enable. When 0, the multiplier FSM holds its state.
- `alu_control`, `alu_src`, `alu_shift_imm`, `sa`, `sign_imm`, `read_data1`, `read_data2`, `rs`, `rt`, `rd`, `reg_dst`, `load_imm` in (4/1/1/5/32/32/32/5/5/5/1/1): decoded instruction fields from ID/EX.
- `reg_write_in`, `mem_to_reg_in`, `mem_read_width_in`, `mem_write_in`, `eop_in` in (1/1/2/4/1): pass-through controls.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in 32: MEM/WB forwarding source.
- `alu_result` out 32: ALU or multiplier result.
- `store_data` out 32: forwarded rt value, used by stores.
- `write_reg` out 5: `rd` when `reg_dst`=1, otherwise `rt`.
- `reg_write_out`, `mem_to_reg_out`, `mem_read_width_out`, `mem_write_out`, `eop_out` out: gated pass-through controls.
- `stall` out 1: freeze ID/EX and the stages upstream of it.

## Operation
- Forwarding for operand A (`rs`) and operand B (`rt`):
  - If EX/MEM has `reg_write`=1, its `rd` is nonzero and equals the operand register, take `exmem_result`.
  - Else, if MEM/WB matches under the same rule, take `memwb_result`.
  - Else take `read_data1` / `read_data2`.
  - Register 0 is never forwarded. EX/MEM wins when both stages match.
- Source B is `sign_imm` when `alu_src`=1, otherwise the forwarded B.
- Shift amount is `sa` when `alu_shift_imm`=1, otherwise A[4:0]. The shifted operand is always the forwarded rt.
- `alu_control` encoding:
  - 0000 AND, 0001 OR, 0010 ADDU, 0011 XOR, 0100 NOR, 0110 SUBU.
  - 0111 SLT (signed compare), 1000 SLTU.
  - 1001 SLL by the shift amount, 1010 SRL, 1011 SRA.
  - 1111 MUL: low 32 bits of the unsigned product.
  - Any other code gives 0.
- Arithmetic wraps modulo 2^32 and no overflow trap is raised.
- When `load_imm`=1, `alu_result` = {`sign_imm`[15:0], 16'h0}, overriding the ALU.
- Multiplier FSM states:
  - IDLE: if `alu_control`=1111 and `step_en`=1, latch multiplicand = A and multiplier = B, clear the accumulator and count, then go to BUSY.
  - BUSY: one shift-add step per enabled edge. After step 32 (count 31), go to DONE.
  - DONE: the accumulator drives `alu_result`. On the next enabled edge go to IDLE.
- `stall` = (op is MUL and state is IDLE) or (state is BUSY). It is deasserted in DONE.
- While `stall`=1, `reg_write_out`, `mem_write_out` and `eop_out` are forced to 0, so EX/MEM receives a bubble. All other outputs pass through unchanged.

## Timing
- Non-MUL ops are purely combinational: the result is valid in the same cycle that ID/EX presents the instruction.
- MUL timing, with ID/EX loading the MUL at negedge N:
  - `stall` rises in cycle N.
  - The FSM enters BUSY at N+1 and DONE at N+33.
  - `stall` is low in cycle N+33, and EX/MEM captures the product at N+34.
  - Total: 33 stall cycles.
- Back-to-back MULs: the second one starts from IDLE one cycle after DONE.
- `step_en`=0 freezes the state and count. `stall` keeps its current value.
- `reset`=1 at an edge forces IDLE with count, accumulator and operand registers all 0. This aborts any multiply in flight, and `stall` drops in the following cycle unless a MUL is still presented.
- Reset takes priority over `step_en`.
- Reset value of all registers is 0. With the ID/EX reset values (all zero) on the inputs, every output is 0.

## Configuration
- `EX_MUL_EN` defined: the multiplier FSM and code 1111 are implemented as described above.
- `EX_MUL_EN` undefined: code 1111 gives 0, `stall` is tied to 0, and no FSM registers exist.

## Test plan
- ADDU, `rs`=1 (5), `rt`=2 (7), no hazards -> `alu_result`=12, `write_reg`=`rd`, `stall`=0.
- EX/MEM `rd`=3 with result 0xAAAA and MEM/WB `rd`=3 with result 0x5555, ADDU `rs`=3 with `rt`=0 -> A=0xAAAA. Repeat with `rd`=0 in both stages -> no forwarding.
- SRA with `sa`=4 and rt=0x80000000 -> 0xF8000000. SLT with -1 vs 1 -> 1. SLTU with the same operands -> 0. LUI with imm 0x1234 -> 0x12340000.
- MUL 0xFFFF × 0x10001 -> `stall` high for exactly 33 cycles, `alu_result`=0xFFFFFFFF in cycle 34, `reg_write_out`=0 while stalled.
- MUL with `reset` pulsed after 10 BUSY cycles -> FSM returns to IDLE, accumulator is 0, and a new full 33-cycle stall follows once reset is released.
- MUL with `step_en` toggled low for 5 cycles mid-BUSY -> total stall is 38 cycles and the product is unchanged.
